// File: rtl/mc_control_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath: walks each instruction
// through fetch/decode/execute/memory/write-back and drives every datapath control.
module mc_control_fsm #(
    parameter int STATE_W       = 4,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EX     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EX     = 4'd10,
        I_WB     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t     state;
    state_t     state_next;
    logic [5:0] opcode_q;
    logic       ready;

    // Without the handshake every memory access completes in one cycle.
    assign ready     = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign state_dbg = STATE_W'(state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            opcode_q <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                opcode_q <= opcode;
            end
        end
    end

    always_comb begin
        state_next    = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        illegal_op    = 1'b0;

        case (state)
            // IR load and PC+4 fire only on the completing cycle of the fetch.
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 3'b010;
                ir_write  = ready;
                pc_write  = ready;
                if (ready) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 3'b010;
                case (opcode)
                    OP_LW, OP_SW:                      state_next = MEM_ADDR;
                    OP_RTYPE:                          state_next = R_EX;
                    OP_BEQ:                            state_next = BRANCH;
                    OP_J:                              state_next = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = I_EX;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = 3'b010;
                state_next = (opcode_q == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (ready) begin
                    state_next = MEM_WB;
                end
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (ready) begin
                    state_next = FETCH;
                end
            end
            R_EX: begin
                alu_src_a  = 1'b1;
                state_next = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_next    = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                state_next = FETCH;
            end
            // The immediate ALU operation comes from the opcode latched in DECODE.
            I_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode_q)
                    OP_ANDI: alu_op = 3'b011;
                    OP_ORI:  alu_op = 3'b100;
                    OP_SLTI: alu_op = 3'b101;
                    default: alu_op = 3'b010;
                endcase
                state_next = I_WB;
            end
            I_WB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: instruction-level reference model pushes
// expected per-cycle control words; a negedge monitor pops and compares them.
module tb_mc_control_fsm;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3, S_MEM_WB = 4,
                   S_MEM_WR = 5, S_R_EX = 6, S_R_WB = 7, S_BRANCH = 8, S_JUMP = 9,
                   S_I_EX = 10, S_I_WB = 11;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t val;
        ctrl_t mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state_dbg;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [5:0] legal_ops [10] = '{6'b000000, 6'b000010, 6'b000100, 6'b001000, 6'b001010,
                                   6'b001100, 6'b001101, 6'b100011, 6'b101011, 6'b000000};

    mc_control_fsm #(.STATE_W(4), .MEM_HANDSHAKE(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b000010, 6'b000100, 6'b001000, 6'b001010,
                          6'b001100, 6'b001101, 6'b100011, 6'b101011};
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            6'b001100: return 3'b011;
            6'b001101: return 3'b100;
            6'b001010: return 3'b101;
            default:   return 3'b010;
        endcase
    endfunction

    // Control word the spec requires in a given state; mask marks fields it fixes.
    function automatic exp_t expectation(input int st, input logic rdy,
                                         input logic [5:0] op_now, input logic [5:0] op_lat);
        exp_t e;
        e = '0;
        e.val.state = st[3:0];
        e.mask.state = '1;
        e.mask.pc_write = 1'b1;
        e.mask.pc_write_cond = 1'b1;
        e.mask.mem_read = 1'b1;
        e.mask.mem_write = 1'b1;
        e.mask.ir_write = 1'b1;
        e.mask.reg_write = 1'b1;
        e.mask.illegal_op = 1'b1;
        case (st)
            S_FETCH: begin
                e.val.mem_read = 1'b1; e.val.alu_src_b = 2'b01; e.val.alu_op = 3'b010;
                e.val.ir_write = rdy;  e.val.pc_write = rdy;
                e.mask.alu_src_a = 1'b1; e.mask.alu_src_b = '1; e.mask.alu_op = '1;
                e.mask.pc_source = '1;   e.mask.i_or_d = 1'b1;
            end
            S_DECODE: begin
                e.val.alu_src_b = 2'b11; e.val.alu_op = 3'b010;
                e.val.illegal_op = !is_legal(op_now);
                e.mask.alu_src_a = 1'b1; e.mask.alu_src_b = '1; e.mask.alu_op = '1;
            end
            S_MEM_ADDR: begin
                e.val.alu_src_a = 1'b1; e.val.alu_src_b = 2'b10; e.val.alu_op = 3'b010;
                e.mask.alu_src_a = 1'b1; e.mask.alu_src_b = '1; e.mask.alu_op = '1;
            end
            S_MEM_RD: begin
                e.val.mem_read = 1'b1; e.val.i_or_d = 1'b1; e.mask.i_or_d = 1'b1;
            end
            S_MEM_WB: begin
                e.val.reg_write = 1'b1; e.val.mem_to_reg = 1'b1;
                e.mask.mem_to_reg = 1'b1; e.mask.reg_dst = 1'b1;
            end
            S_MEM_WR: begin
                e.val.mem_write = 1'b1; e.val.i_or_d = 1'b1; e.mask.i_or_d = 1'b1;
            end
            S_R_EX: begin
                e.val.alu_src_a = 1'b1; e.val.alu_src_b = 2'b00; e.val.alu_op = 3'b000;
                e.mask.alu_src_a = 1'b1; e.mask.alu_src_b = '1; e.mask.alu_op = '1;
            end
            S_R_WB: begin
                e.val.reg_write = 1'b1; e.val.reg_dst = 1'b1;
                e.mask.mem_to_reg = 1'b1; e.mask.reg_dst = 1'b1;
            end
            S_BRANCH: begin
                e.val.alu_src_a = 1'b1; e.val.alu_op = 3'b001;
                e.val.pc_write_cond = 1'b1; e.val.pc_source = 2'b01;
                e.mask.alu_src_a = 1'b1; e.mask.alu_src_b = '1; e.mask.alu_op = '1;
                e.mask.pc_source = '1;
            end
            S_JUMP: begin
                e.val.pc_write = 1'b1; e.val.pc_source = 2'b10; e.mask.pc_source = '1;
            end
            S_I_EX: begin
                e.val.alu_src_a = 1'b1; e.val.alu_src_b = 2'b10; e.val.alu_op = imm_alu_op(op_lat);
                e.mask.alu_src_a = 1'b1; e.mask.alu_src_b = '1; e.mask.alu_op = '1;
            end
            S_I_WB: begin
                e.val.reg_write = 1'b1;
                e.mask.mem_to_reg = 1'b1; e.mask.reg_dst = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Called just after a rising edge: drive one cycle of inputs, queue the expected word.
    task automatic applyStimulus(input logic [5:0] op, input logic rdy, input logic r,
                                 input int st, input logic [5:0] lat);
        opcode    = op;
        mem_ready = rdy;
        rst       = r;
        exp_q.push_back(expectation(st, rdy, op, lat));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] rand_op();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rand_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic mem_stage(input int st, input int stalls, input logic [5:0] lat);
        for (int i = 0; i < stalls; i++) applyStimulus(rand_op(), 1'b0, 1'b0, st, lat);
        applyStimulus(rand_op(), 1'b1, 1'b0, st, lat);
    endtask

    // One instruction as its sequence of states; stalls < 0 picks random stall lengths.
    task automatic run_instr(input logic [5:0] op, input int stalls);
        int k;
        k = (stalls < 0) ? $urandom_range(0, 3) : 0;
        mem_stage(S_FETCH, k, 6'd0);
        applyStimulus(op, rand_bit(), 1'b0, S_DECODE, op);
        k = (stalls < 0) ? $urandom_range(0, 3) : stalls;
        case (op)
            6'b100011: begin
                applyStimulus(rand_op(), rand_bit(), 1'b0, S_MEM_ADDR, op);
                mem_stage(S_MEM_RD, k, op);
                applyStimulus(rand_op(), rand_bit(), 1'b0, S_MEM_WB, op);
            end
            6'b101011: begin
                applyStimulus(rand_op(), rand_bit(), 1'b0, S_MEM_ADDR, op);
                mem_stage(S_MEM_WR, k, op);
            end
            6'b000000: begin
                applyStimulus(rand_op(), rand_bit(), 1'b0, S_R_EX, op);
                applyStimulus(rand_op(), rand_bit(), 1'b0, S_R_WB, op);
            end
            6'b000100: applyStimulus(rand_op(), rand_bit(), 1'b0, S_BRANCH, op);
            6'b000010: applyStimulus(rand_op(), rand_bit(), 1'b0, S_JUMP, op);
            6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
                applyStimulus(rand_op(), rand_bit(), 1'b0, S_I_EX, op);
                applyStimulus(rand_op(), rand_bit(), 1'b0, S_I_WB, op);
            end
            default: ;
        endcase
    endtask

    task automatic checkOutput(input exp_t e);
        ctrl_t act;
        act = '{state_dbg, pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                illegal_op};
        checks++;
        if (((act ^ e.val) & e.mask) != '0) begin
            failures++;
            $display("[TB] FAIL ctrl t=%0t got=%06h expected=%06h care=%06h (state got %0d want %0d)",
                     $time, act, e.val, e.mask, act.state, e.val.state);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        rst       = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'd0;
        @(posedge clk);
        #1;
        applyStimulus(rand_op(), 1'b0, 1'b1, S_FETCH, 6'd0);
        applyStimulus(rand_op(), 1'b0, 1'b0, S_FETCH, 6'd0);

        run_instr(6'b000000, 0);
        run_instr(6'b100011, 3);
        run_instr(6'b101011, 0);
        run_instr(6'b000100, 0);
        run_instr(6'b001000, 0);
        run_instr(6'b001100, 0);
        run_instr(6'b001101, 0);
        run_instr(6'b001010, 0);
        run_instr(6'b111111, 0);
        run_instr(6'b000010, 0);

        // Reset held two edges in the middle of a load's memory stall.
        applyStimulus(rand_op(), 1'b1, 1'b0, S_FETCH, 6'd0);
        applyStimulus(6'b100011, 1'b1, 1'b0, S_DECODE, 6'b100011);
        applyStimulus(rand_op(), 1'b1, 1'b0, S_MEM_ADDR, 6'b100011);
        applyStimulus(rand_op(), 1'b0, 1'b0, S_MEM_RD, 6'b100011);
        applyStimulus(rand_op(), 1'b0, 1'b1, S_MEM_RD, 6'b100011);
        applyStimulus(rand_op(), 1'b0, 1'b1, S_FETCH, 6'd0);
        applyStimulus(rand_op(), 1'b0, 1'b0, S_FETCH, 6'd0);

        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) == 0) ? rand_op() : legal_ops[$urandom_range(0, 9)];
            run_instr(op, -1);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain got=%0d pending expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control state machine for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and write-back for each instruction.
- Drives the 3-bit alu_op consumed by alu_control, plus all mux selects and write enables for the PC, IR, register file and memory.
- Stalls on a single-bit memory ready handshake.

Parameters:
- STATE_W, 4, width of the state register and of the state_dbg output.
- MEM_HANDSHAKE, 1, 1 = wait on mem_ready in memory states; 0 = treat mem_ready as constantly 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  6  IR[31:26]; sampled only in DECODE.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero (beq).
- pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d  output  1  0 = PC address, 1 = ALUOut address.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load enable.
- mem_to_reg  output  1  1 = write-back data from MDR.
- reg_dst  output  1  1 = rd, 0 = rt.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  0 = PC, 1 = register A.
- alu_src_b  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_op  output  3  000 R-type (funct), 001 sub, 010 add, 011 and, 100 or, 101 slt.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- state_dbg  output  STATE_W  current state encoding.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EX=6, R_WB=7, BRANCH=8, JUMP=9, I_EX=10, I_WB=11.
- Reset: on a clk edge with rst=1, state <= FETCH, latched opcode <= 0. rst has priority over every transition, including mid-stall.
- All outputs are Moore (functions of state, plus mem_ready where stated). They are combinational from state, so after reset they take FETCH values: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=010, pc_source=00, i_or_d=0; all other enables 0.
- FETCH:
  - mem_read=1, alu_src_b=01, alu_op=010.
  - ir_write and pc_write = mem_ready. Both are 0 while stalled, so PC+4 and the IR load happen exactly once.
  - Exit to DECODE on mem_ready=1; otherwise hold.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=010 (branch target precompute).
  - Latch opcode into an internal register.
  - Next state: 100011/101011 -> MEM_ADDR; 000000 -> R_EX; 000100 -> BRANCH; 000010 -> JUMP; 001000/001100/001101/001010 -> I_EX.
  - Any other opcode -> FETCH with illegal_op=1 for this cycle only. No write enables are asserted.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=010. Next is MEM_RD if the latched opcode is lw, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH. mem_write stays high for the whole stall.
- R_EX: alu_src_a=1, alu_src_b=00, alu_op=000. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01. Next FETCH.
- JUMP: pc_write=1, pc_source=10. Next FETCH.
- I_EX: alu_src_a=1, alu_src_b=10. alu_op from latched opcode: addi 010, andi 011, ori 100, slti 101. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- Cycle counts with mem_ready tied high: lw 5, sw 4, R-type 4, addi/andi/ori/slti 4, beq 3, j 3.
- MEM_HANDSHAKE=0: mem_ready is ignored; memory states last exactly one cycle.
- Unused state encodings 12-15 -> FETCH on the next edge, with no enables asserted.
- Invariant: mem_read and mem_write are never both 1. reg_write is never 1 outside MEM_WB, R_WB and I_WB.

Test Plan:
- Reset: rst=1 for 2 edges mid-MEM_RD stall, then release -> state_dbg=0, mem_read=1, alu_op=010, pc_write=0 until mem_ready.
- R-type: opcode=000000, mem_ready=1 -> state sequence 0,1,6,7,0; alu_op=000 in state 6; reg_write=1 with reg_dst=1 only in state 7.
- lw with stall: opcode=100011, mem_ready low for 3 cycles in MEM_RD -> state 3 held 4 cycles; reg_write=1 and mem_to_reg=1 for exactly 1 cycle afterwards.
- sw then beq: opcode=101011 gives sequence 0,1,2,5,0 with mem_write=1 only in state 5. Next opcode=000100 gives 0,1,8,0 with alu_op=001 and pc_write_cond=1 in state 8.
- Immediates: opcodes 001000/001100/001101/001010 -> alu_op in state 10 is 010/011/100/101 respectively.
- Illegal: opcode=111111 -> illegal_op pulses 1 cycle in DECODE, next state FETCH, no reg_write/mem_write/pc_write asserted.
